bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Round-robin owner arbiter for the CPU's shared 8-bit internal data bus. It sits directly upstream of the per-source 8-bit tristate drivers and produces their output-enable lines. It guarantees at most one driver is enabled at any time, inserts dead cycles between owners to avoid contention, and caps burst length so no source can starve the others.

## Interface
- `N`, 4: number of bus sources (2..8).
- `TURNAROUND`, 1: dead cycles with no driver enabled after each release (1..3).
- `MAX_BURST`, 16: maximum consecutive drive cycles per grant (2..255).

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `req`  in  N  per-source bus request; level, held until served.
- `last`  in  N  per-source "final byte this cycle"; sampled only for the current owner.
- `drive_en`  out  N  one-hot-or-zero output enables to the tristate drivers.
- `owner`  out  clog2(N) (min 1)  index of the current owner; valid while `bus_busy`=1.
- `bus_busy`  out  1  high whenever any `drive_en` bit is high.
- `preempt`  out  1  one-cycle pulse when a grant is ended by the burst cap.

## Operation
- All outputs are registered. On reset: state IDLE, `drive_en`=0, `owner`=0, `bus_busy`=0, `preempt`=0, round-robin pointer `ptr`=0, burst counter=0.
- States: IDLE, DRIVE, TURN.
- IDLE:
  - If `req`≠0, select the first set bit scanning from `ptr` upward with wrap to 0.
  - Next cycle: DRIVE, `drive_en[sel]`=1, `owner`=sel, burst counter=1.
  - If `req`=0, stay in IDLE.
- DRIVE: one byte moves per cycle. The grant ends at the edge after any of these conditions:
  - `last[owner]`=1;
  - `req[owner]`=0;
  - burst counter = `MAX_BURST`. In this case `preempt` pulses in the first TURN cycle.
- Otherwise the burst counter increments and DRIVE holds.
- Requests from non-owners are ignored in DRIVE.
- On release:
  - Go to TURN with `drive_en`=0.
  - Set `ptr`=(`owner`+1) mod N.
  - Clear the burst counter.
- TURN: hold `drive_en`=0 for exactly `TURNAROUND` cycles, then go to IDLE.
- `bus_busy` equals OR of `drive_en`; it is high only in DRIVE.
- A preempted owner that still requests is re-served only after every other requester it passed in round-robin order.
- Invariant: `drive_en` is never more than one-hot, on every cycle including reset entry and exit.

## Timing
- Grant latency: `req` first seen high in IDLE at edge k → `drive_en` high after edge k+1.
- Minimum gap between successive owners' `drive_en`: `TURNAROUND`+1 cycles (TURN plus IDLE arbitration). The same owner re-granted observes the same gap.
- A `last` pulse coincident with the first DRIVE cycle yields a one-cycle drive.
- `last` and the burst cap in the same cycle: release happens once and `preempt` pulses (cap wins for reporting).
- `req[owner]` dropping together with `last`: normal release, no `preempt`.
- `reset_n` low mid-DRIVE: `drive_en` is 0 after that edge; no TURN is inserted. Reset forces all drivers off immediately.
- Wrap-around: `ptr`=N-1 with `req[N-1]`=0 and `req[0]`=1 → source 0 is selected.

## Test plan
- Reset: hold `reset_n`=0 for 3 cycles with `req`=4'b1111. Required: `drive_en`=0 and `bus_busy`=0 throughout. The first grant after release is to source 0, on the 2nd edge.
- Round-robin: `req`=4'b1111, each owner asserts `last` on its 2nd drive cycle, `TURNAROUND`=1. Required: owners 0,1,2,3,0 in order, each with 2 drive cycles, separated by 2 idle cycles.
- Burst cap: `MAX_BURST`=4, `req`=4'b0101 held, `last` never set. Required: source 0 drives exactly 4 cycles, `preempt` pulses once, then source 2 drives 4 cycles, then source 0 again.
- Request drop: source 1 granted; `req[1]` is deasserted on its 3rd drive cycle. Required: `drive_en` is 0 on the next edge, `preempt`=0, and `ptr` advances to 2.
- Wrap and single requester: only `req[3]` high with `ptr`=3, `last` every cycle. Required: source 3 is repeatedly granted for 1 cycle each, with a gap of `TURNAROUND`+1 cycles.
- Reset mid-burst: assert `reset_n`=0 on the 2nd drive cycle of source 2. Required: `drive_en`=0 next edge and `ptr`=0 after reset. The one-hot-or-zero checker never fires during the whole run.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - request/enable bundle between bus sources and the owner arbiter
interface bus_arbiter_if #(
    parameter int N  = 4,
    parameter int OW = (N > 1) ? $clog2(N) : 1
);
    logic [N-1:0]  req;
    logic [N-1:0]  last;
    logic [N-1:0]  drive_en;
    logic [OW-1:0] owner;
    logic          bus_busy;
    logic          preempt;

    // Arbiter side: consumes requests, produces the tristate enables.
    modport master (
        input  req,
        input  last,
        output drive_en,
        output owner,
        output bus_busy,
        output preempt
    );

    // Source side: raises requests, observes its enable.
    modport slave (
        output req,
        output last,
        input  drive_en,
        input  owner,
        input  bus_busy,
        input  preempt
    );
endinterface

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin owner arbiter with turnaround and burst cap for the 8-bit internal bus
module bus_arbiter #(
    parameter int N          = 4,
    parameter int TURNAROUND = 1,
    parameter int MAX_BURST  = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    bus_arbiter_if.master bus
);
    localparam int OW = (N > 1) ? $clog2(N) : 1;
    localparam int KW = OW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_TURN  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [OW-1:0] ptr_q, ptr_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [N-1:0]  drive_en_q, drive_en_d;
    logic [7:0]    burst_q, burst_d;
    logic [1:0]    turn_q, turn_d;
    logic          preempt_q, preempt_d;
    logic          busy_q, busy_d;

    logic [OW-1:0] sel;
    logic          found;
    logic [KW-1:0] k;
    logic [OW-1:0] ptr_next;
    logic          cap_hit;
    logic          release_now;

    // Pick the first requester at or after the round-robin pointer, wrapping past N-1.
    always_comb begin
        sel   = ptr_q;
        found = 1'b0;
        k     = '0;
        for (int i = 0; i < N; i++) begin
            k = {1'b0, ptr_q} + KW'(i);
            if (k >= KW'(N)) begin
                k = k - KW'(N);
            end
            if (!found && bus.req[k[OW-1:0]]) begin
                found = 1'b1;
                sel   = k[OW-1:0];
            end
        end
    end

    assign ptr_next    = (owner_q == OW'(N - 1)) ? '0 : owner_q + 1'b1;
    assign cap_hit     = (burst_q == 8'(MAX_BURST));
    assign release_now = bus.last[owner_q] | ~bus.req[owner_q] | cap_hit;

    // Next-state logic; the cap is reported even when last/req-drop coincide with it.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        drive_en_d = drive_en_q;
        burst_d    = burst_q;
        turn_d     = turn_q;
        preempt_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                drive_en_d = '0;
                if (found) begin
                    state_d    = S_DRIVE;
                    drive_en_d = N'(1) << sel;
                    owner_d    = sel;
                    burst_d    = 8'd1;
                end
            end
            S_DRIVE: begin
                if (release_now) begin
                    state_d    = S_TURN;
                    drive_en_d = '0;
                    ptr_d      = ptr_next;
                    burst_d    = 8'd0;
                    turn_d     = 2'd1;
                    preempt_d  = cap_hit;
                end else begin
                    burst_d = burst_q + 8'd1;
                end
            end
            S_TURN: begin
                drive_en_d = '0;
                if (turn_q == 2'(TURNAROUND)) begin
                    state_d = S_IDLE;
                    turn_d  = 2'd0;
                end else begin
                    turn_d = turn_q + 2'd1;
                end
            end
            default: begin
                state_d    = S_IDLE;
                drive_en_d = '0;
                burst_d    = 8'd0;
                turn_d     = 2'd0;
            end
        endcase
        busy_d = |drive_en_d;
    end

    // State and output registers; reset turns every driver off on the same edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            drive_en_q <= '0;
            burst_q    <= 8'd0;
            turn_q     <= 2'd0;
            preempt_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            drive_en_q <= drive_en_d;
            burst_q    <= burst_d;
            turn_q     <= turn_d;
            preempt_q  <= preempt_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.drive_en = drive_en_q;
    assign bus.owner    = owner_q;
    assign bus.bus_busy = busy_q;
    assign bus.preempt  = preempt_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - scoreboard bench for bus_arbiter (N=4, TURNAROUND=1, MAX_BURST=4)
module tb_bus_arbiter;
    typedef struct packed {
        logic [3:0] r;
        logic [3:0] l;
        logic       rn;
        logic [3:0] de;
        logic       pre;
    } stim_t;

    typedef struct packed {
        logic [3:0] de;
        logic       pre;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    logic mon_en = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];

    bus_arbiter_if #(.N(4)) bus ();

    bus_arbiter #(
        .N(4),
        .TURNAROUND(1),
        .MAX_BURST(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic stim_t mk(input logic [3:0] r, input logic [3:0] l, input logic rn,
                                 input logic [3:0] de, input logic pre);
        stim_t s;
        s.r = r; s.l = l; s.rn = rn; s.de = de; s.pre = pre;
        return s;
    endfunction

    function automatic logic [1:0] idx_of(input logic [3:0] oh);
        logic [1:0] v;
        v = 2'd0;
        for (int i = 0; i < 4; i++) if (oh[i]) v = 2'(i);
        return v;
    endfunction

    // Drive one cycle of stimulus at the falling edge, queue what the outputs must be after the next rising edge.
    task automatic step(input stim_t s);
        bus.req  = s.r;
        bus.last = s.l;
        reset_n  = s.rn;
        exp_q.push_back({s.de, s.pre});
        @(posedge clk);
        @(negedge clk);
    endtask

    // Structural invariants checked every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if ($countones(bus.drive_en) > 1 || bus.bus_busy !== (|bus.drive_en)) begin
                failures++;
                $display("FAIL onehot_busy t=%0t drive_en=%b bus_busy=%b", $time, bus.drive_en, bus.bus_busy);
            end
        end
    end

    task automatic test_reset();
        stim_t s[$];
        exp_t  e;
        for (int i = 0; i < 3; i++) s.push_back(mk(4'hF, 4'h0, 1'b0, 4'h0, 1'b0));
        s.push_back(mk(4'hF, 4'h0, 1'b1, 4'h1, 1'b0));
        s.push_back(mk(4'hF, 4'h0, 1'b1, 4'h1, 1'b0));
        foreach (s[i]) begin
            step(s[i]);
            e = exp_q.pop_front();
            checks += 2;
            if (bus.drive_en !== e.de) begin failures++; $display("FAIL reset[%0d] drive_en got=%b exp=%b", i, bus.drive_en, e.de); end
            if (bus.preempt !== e.pre) begin failures++; $display("FAIL reset[%0d] preempt got=%b exp=%b", i, bus.preempt, e.pre); end
            if (e.de != 4'h0) begin
                checks++;
                if (bus.owner !== idx_of(e.de)) begin failures++; $display("FAIL reset[%0d] owner got=%0d exp=%0d", i, bus.owner, idx_of(e.de)); end
            end
        end
    endtask

    task automatic test_round_robin();
        stim_t s[$];
        exp_t  e;
        logic [3:0] g;
        s.push_back(mk(4'hF, 4'h0, 1'b0, 4'h0, 1'b0));
        for (int o = 0; o < 5; o++) begin
            g = 4'h1 << (o % 4);
            for (int c = 0; c < 4; c++)
                s.push_back(mk(4'hF, (c == 2) ? g : 4'h0, 1'b1, (c < 2) ? g : 4'h0, 1'b0));
        end
        foreach (s[i]) begin
            step(s[i]);
            e = exp_q.pop_front();
            checks += 2;
            if (bus.drive_en !== e.de) begin failures++; $display("FAIL round_robin[%0d] drive_en got=%b exp=%b", i, bus.drive_en, e.de); end
            if (bus.preempt !== e.pre) begin failures++; $display("FAIL round_robin[%0d] preempt got=%b exp=%b", i, bus.preempt, e.pre); end
            if (e.de != 4'h0) begin
                checks++;
                if (bus.owner !== idx_of(e.de)) begin failures++; $display("FAIL round_robin[%0d] owner got=%0d exp=%0d", i, bus.owner, idx_of(e.de)); end
            end
        end
    endtask

    task automatic test_burst_cap();
        stim_t s[$];
        exp_t  e;
        s.push_back(mk(4'h5, 4'h0, 1'b0, 4'h0, 1'b0));
        for (int i = 0; i < 4; i++) s.push_back(mk(4'h5, 4'h0, 1'b1, 4'h1, 1'b0));
        s.push_back(mk(4'h5, 4'h0, 1'b1, 4'h0, 1'b1));
        s.push_back(mk(4'h5, 4'h0, 1'b1, 4'h0, 1'b0));
        for (int i = 0; i < 4; i++) s.push_back(mk(4'h5, 4'h0, 1'b1, 4'h4, 1'b0));
        s.push_back(mk(4'h5, 4'h0, 1'b1, 4'h0, 1'b1));
        s.push_back(mk(4'h5, 4'h0, 1'b1, 4'h0, 1'b0));
        s.push_back(mk(4'h5, 4'h0, 1'b1, 4'h1, 1'b0));
        foreach (s[i]) begin
            step(s[i]);
            e = exp_q.pop_front();
            checks += 2;
            if (bus.drive_en !== e.de) begin failures++; $display("FAIL burst_cap[%0d] drive_en got=%b exp=%b", i, bus.drive_en, e.de); end
            if (bus.preempt !== e.pre) begin failures++; $display("FAIL burst_cap[%0d] preempt got=%b exp=%b", i, bus.preempt, e.pre); end
            if (e.de != 4'h0) begin
                checks++;
                if (bus.owner !== idx_of(e.de)) begin failures++; $display("FAIL burst_cap[%0d] owner got=%0d exp=%0d", i, bus.owner, idx_of(e.de)); end
            end
        end
    endtask

    task automatic test_req_drop();
        stim_t s[$];
        exp_t  e;
        s.push_back(mk(4'h2, 4'h0, 1'b0, 4'h0, 1'b0));
        for (int i = 0; i < 3; i++) s.push_back(mk(4'h2, 4'h0, 1'b1, 4'h2, 1'b0));
        s.push_back(mk(4'hD, 4'h0, 1'b1, 4'h0, 1'b0));
        s.push_back(mk(4'hD, 4'h0, 1'b1, 4'h0, 1'b0));
        s.push_back(mk(4'hD, 4'h0, 1'b1, 4'h4, 1'b0));
        foreach (s[i]) begin
            step(s[i]);
            e = exp_q.pop_front();
            checks += 2;
            if (bus.drive_en !== e.de) begin failures++; $display("FAIL req_drop[%0d] drive_en got=%b exp=%b", i, bus.drive_en, e.de); end
            if (bus.preempt !== e.pre) begin failures++; $display("FAIL req_drop[%0d] preempt got=%b exp=%b", i, bus.preempt, e.pre); end
            if (e.de != 4'h0) begin
                checks++;
                if (bus.owner !== idx_of(e.de)) begin failures++; $display("FAIL req_drop[%0d] owner got=%0d exp=%0d", i, bus.owner, idx_of(e.de)); end
            end
        end
    endtask

    task automatic test_wrap_single();
        stim_t s[$];
        exp_t  e;
        s.push_back(mk(4'h4, 4'h0, 1'b0, 4'h0, 1'b0));
        s.push_back(mk(4'h4, 4'h0, 1'b1, 4'h4, 1'b0));
        s.push_back(mk(4'h4, 4'h4, 1'b1, 4'h0, 1'b0));
        s.push_back(mk(4'h1, 4'h0, 1'b1, 4'h0, 1'b0));
        s.push_back(mk(4'h1, 4'h0, 1'b1, 4'h1, 1'b0));
        s.push_back(mk(4'h1, 4'h1, 1'b1, 4'h0, 1'b0));
        s.push_back(mk(4'h8, 4'h8, 1'b1, 4'h0, 1'b0));
        for (int r = 0; r < 3; r++) begin
            s.push_back(mk(4'h8, 4'h8, 1'b1, 4'h8, 1'b0));
            s.push_back(mk(4'h8, 4'h8, 1'b1, 4'h0, 1'b0));
            s.push_back(mk(4'h8, 4'h8, 1'b1, 4'h0, 1'b0));
        end
        foreach (s[i]) begin
            step(s[i]);
            e = exp_q.pop_front();
            checks += 2;
            if (bus.drive_en !== e.de) begin failures++; $display("FAIL wrap_single[%0d] drive_en got=%b exp=%b", i, bus.drive_en, e.de); end
            if (bus.preempt !== e.pre) begin failures++; $display("FAIL wrap_single[%0d] preempt got=%b exp=%b", i, bus.preempt, e.pre); end
            if (e.de != 4'h0) begin
                checks++;
                if (bus.owner !== idx_of(e.de)) begin failures++; $display("FAIL wrap_single[%0d] owner got=%0d exp=%0d", i, bus.owner, idx_of(e.de)); end
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t s[$];
        exp_t  e;
        s.push_back(mk(4'h1, 4'h0, 1'b0, 4'h0, 1'b0));
        for (int i = 0; i < 4; i++) s.push_back(mk(4'h1, 4'h0, 1'b1, 4'h1, 1'b0));
        s.push_back(mk(4'h1, 4'h1, 1'b1, 4'h0, 1'b1));
        s.push_back(mk(4'h1, 4'h0, 1'b1, 4'h0, 1'b0));
        s.push_back(mk(4'h1, 4'h1, 1'b1, 4'h1, 1'b0));
        s.push_back(mk(4'h1, 4'h1, 1'b1, 4'h0, 1'b0));
        s.push_back(mk(4'h1, 4'h0, 1'b1, 4'h0, 1'b0));
        s.push_back(mk(4'h1, 4'h0, 1'b1, 4'h1, 1'b0));
        s.push_back(mk(4'h0, 4'h1, 1'b1, 4'h0, 1'b0));
        s.push_back(mk(4'h0, 4'h0, 1'b1, 4'h0, 1'b0));
        foreach (s[i]) begin
            step(s[i]);
            e = exp_q.pop_front();
            checks += 2;
            if (bus.drive_en !== e.de) begin failures++; $display("FAIL back_to_back[%0d] drive_en got=%b exp=%b", i, bus.drive_en, e.de); end
            if (bus.preempt !== e.pre) begin failures++; $display("FAIL back_to_back[%0d] preempt got=%b exp=%b", i, bus.preempt, e.pre); end
            if (e.de != 4'h0) begin
                checks++;
                if (bus.owner !== idx_of(e.de)) begin failures++; $display("FAIL back_to_back[%0d] owner got=%0d exp=%0d", i, bus.owner, idx_of(e.de)); end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        stim_t s[$];
        exp_t  e;
        s.push_back(mk(4'h4, 4'h0, 1'b0, 4'h0, 1'b0));
        s.push_back(mk(4'h4, 4'h0, 1'b1, 4'h4, 1'b0));
        s.push_back(mk(4'h4, 4'h0, 1'b1, 4'h4, 1'b0));
        s.push_back(mk(4'h4, 4'h0, 1'b0, 4'h0, 1'b0));
        s.push_back(mk(4'hF, 4'h0, 1'b1, 4'h1, 1'b0));
        foreach (s[i]) begin
            step(s[i]);
            e = exp_q.pop_front();
            checks += 2;
            if (bus.drive_en !== e.de) begin failures++; $display("FAIL reset_mid[%0d] drive_en got=%b exp=%b", i, bus.drive_en, e.de); end
            if (bus.preempt !== e.pre) begin failures++; $display("FAIL reset_mid[%0d] preempt got=%b exp=%b", i, bus.preempt, e.pre); end
            if (e.de != 4'h0) begin
                checks++;
                if (bus.owner !== idx_of(e.de)) begin failures++; $display("FAIL reset_mid[%0d] owner got=%0d exp=%0d", i, bus.owner, idx_of(e.de)); end
            end
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        bus.req  = 4'h0;
        bus.last = 4'h0;
        @(negedge clk);
        mon_en = 1'b1;
        test_reset();
        test_round_robin();
        test_burst_cap();
        test_req_drop();
        test_wrap_single();
        test_back_to_back();
        test_reset_mid_burst();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
